// File: rtl/lzc_arbiter.sv
// lzc_arbiter: two-requester round-robin front end for a shared leading-zero
// counter, producing the count, zero flag and normalised operand.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req0_valid/ready    requester 0 handshake, req0_data operand
//   req1_valid/ready    requester 1 handshake, req1_data operand
//   lzc_a               operand to the shared counter
//   lzc_z               count from the shared counter ([5:0] used)
//   resp_valid/ready    response handshake
//   resp_id             requester owning the response
//   resp_count          leading-zero count, 0..64
//   resp_norm           operand << resp_count
//   resp_zero           operand was all zeros
//   busy                high outside IDLE
module lzc_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_data,
  output logic [63:0] lzc_a,
  input  logic [7:0]  lzc_z,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [6:0]  resp_count,
  output logic [63:0] resp_norm,
  output logic        resp_zero,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    RESP
  } state_t;

  state_t      state;
  state_t      stateNext;

  logic        lastGrant;
  logic        grant;
  logic        isIdle;
  logic        accept;
  logic        opZero;

  logic [63:0] operand;
  logic [63:0] norm;
  logic [6:0]  count;
  logic        zero;
  logic        id;

  // Upper counter bits carry nothing for a 64-bit operand.
  logic        unusedLzcHi;
  assign unusedLzcHi = ^lzc_z[7:6];

  assign isIdle = (state == IDLE);
  assign opZero = (operand == 64'd0);

  // Round-robin pick: a lone valid wins, a tie goes
  // to the requester not served last time.
  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (req0_valid & req1_valid):
        grant = ~lastGrant;
      (~req0_valid & req1_valid):
        grant = 1'b1;
      default:
        grant = 1'b0;
    endcase
  end

  assign req0_ready = isIdle & req0_valid & ~grant;
  assign req1_ready = isIdle & req1_valid & grant;

  assign accept = (req0_valid & req0_ready)
                | (req1_valid & req1_ready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stateNext = LOAD;
        end
      end
      LOAD: begin
        stateNext = SHIFT;
      end
      SHIFT: begin
        stateNext = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy       = 1'b1;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
      end
      RESP: begin
        resp_valid = 1'b1;
      end
      default: begin
        busy       = 1'b1;
        resp_valid = 1'b0;
      end
    endcase
  end

  // Datapath. The counter reports 0 for an all-zero
  // operand, so that case is patched to 64 here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand   <= 64'd0;
      id        <= 1'b0;
      lastGrant <= 1'b1;
      count     <= 7'd0;
      zero      <= 1'b0;
      norm      <= 64'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            operand   <= grant ? req1_data
                               : req0_data;
            id        <= grant;
            lastGrant <= grant;
          end
        end
        LOAD: begin
          zero  <= opZero;
          count <= opZero ? 7'd64
                          : {1'b0, lzc_z[5:0]};
        end
        SHIFT: begin
          norm <= count[6] ? 64'd0
                           : operand << count[5:0];
        end
        default: begin
        end
      endcase
    end
  end

  assign lzc_a      = operand;
  assign resp_id    = id;
  assign resp_count = count;
  assign resp_norm  = norm;
  assign resp_zero  = zero;

  a_oneReady: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready)
  );

  a_respHold: assert property (
    @(posedge clk) disable iff (!rst_n)
    (resp_valid && !resp_ready) |=>
      (resp_valid && $stable(resp_norm)
       && $stable(resp_count)
       && $stable(resp_id)
       && $stable(resp_zero))
  );

  a_countRange: assert property (
    @(posedge clk) disable iff (!rst_n)
    resp_valid |-> (resp_count <= 7'd64)
  );

endmodule

// File: tb/tb_lzc_arbiter.sv
// tb_lzc_arbiter: scoreboard bench for lzc_arbiter with a
// behavioural model of the shared leading-zero counter.
module tb_lzc_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic        req0_ready;
  logic [63:0] req0_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [63:0] req1_data;
  logic [63:0] lzc_a;
  logic [7:0]  lzc_z;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [6:0]  resp_count;
  logic [63:0] resp_norm;
  logic        resp_zero;
  logic        busy;

  typedef struct {
    logic        id;
    logic [6:0]  cnt;
    logic [63:0] norm;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   nCmp;
  int   nErr;
  logic lastG;

  lzc_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .lzc_a      (lzc_a),
    .lzc_z      (lzc_z),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_count (resp_count),
    .resp_norm  (resp_norm),
    .resp_zero  (resp_zero),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lzcRef(input logic [63:0] d);
    for (int i = 63; i >= 0; i--) begin
      if (d[i]) return 63 - i;
    end
    return 64;
  endfunction

  // Shared counter: reports 0 for an all-zero input.
  always_comb begin
    lzc_z = 8'd0;
    if (lzc_a != 64'd0) lzc_z = 8'(lzcRef(lzc_a));
  end

  // Drive one request (caller is just after a posedge, DUT in IDLE);
  // returns just after the accepting edge with valids still driven.
  task automatic issue(input logic v0, input logic [63:0] d0,
                       input logic v1, input logic [63:0] d1);
    logic        g;
    logic [1:0]  expRdy;
    logic [63:0] d;
    exp_t        e;
    int          c;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    g = (v0 && v1) ? ~lastG : v1;
    expRdy = g ? 2'b01 : 2'b10;
    @(negedge clk);
    nCmp++;
    if ({req0_ready, req1_ready} !== expRdy) begin
      nErr++;
      $display("FAIL grant: ready={r0,r1}=%b expected %b",
               {req0_ready, req1_ready}, expRdy);
    end
    d = g ? d1 : d0;
    c = lzcRef(d);
    e.id   = g;
    e.cnt  = 7'(c);
    e.norm = (c == 64) ? 64'd0 : d << c;
    e.zero = (d == 64'd0);
    sb.push_back(e);
    lastG = g;
    @(posedge clk);
    #1;
  endtask

  // Wait for the response, optionally stall it, then pop and compare.
  task automatic collect(input int stall,
                         output logic oId, output logic [6:0] oCnt,
                         output logic [63:0] oNorm, output logic oZero);
    int          lat;
    logic [72:0] snap;
    exp_t        e;
    resp_ready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 10);
    nCmp++;
    if (!resp_valid || lat != 3) begin
      nErr++;
      $display("FAIL latency: resp_valid=%b after %0d cycles, expected 1 after 3",
               resp_valid, lat);
    end
    snap = {resp_id, resp_count, resp_norm, resp_zero};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      nCmp++;
      if ({resp_valid, busy, req0_ready, req1_ready,
           resp_id, resp_count, resp_norm, resp_zero}
          !== {4'b1100, snap}) begin
        nErr++;
        $display("FAIL hold: cyc %0d valid=%b busy=%b rdy=%b%b out=%h expected 1 1 00 %h",
                 i, resp_valid, busy, req0_ready, req1_ready,
                 {resp_id, resp_count, resp_norm, resp_zero}, snap);
      end
    end
    oId   = resp_id;
    oCnt  = resp_count;
    oNorm = resp_norm;
    oZero = resp_zero;
    nCmp++;
    if (sb.size() == 0) begin
      nErr++;
      $display("FAIL scoreboard: response with empty queue, got 1 expected 0");
    end else begin
      e = sb.pop_front();
      if ({oId, oCnt, oNorm, oZero} !== {e.id, e.cnt, e.norm, e.zero}) begin
        nErr++;
        $display("FAIL resp: id=%b cnt=%0d norm=%h zero=%b expected id=%b cnt=%0d norm=%h zero=%b",
                 oId, oCnt, oNorm, oZero, e.id, e.cnt, e.norm, e.zero);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    nCmp++;
    if ({resp_valid, busy} !== 2'b00) begin
      nErr++;
      $display("FAIL release: valid=%b busy=%b expected 0 0",
               resp_valid, busy);
    end
  endtask

  task automatic test_reset;
    #1;
    nCmp++;
    if ({req0_ready, req1_ready, resp_valid, busy, resp_id, resp_zero,
         resp_count, resp_norm, lzc_a} !== '0) begin
      nErr++;
      $display("FAIL reset_outputs: got nonzero %b%b%b%b expected all 0",
               req0_ready, req1_ready, resp_valid, busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lastG = 1'b1;
    @(posedge clk);
    #1;
    nCmp++;
    if (busy !== 1'b0) begin
      nErr++;
      $display("FAIL idle_after_reset: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_contention;
    logic        id;
    logic [6:0]  c;
    logic [63:0] n;
    logic        z;
    logic [2:0]  ids;
    logic [2:0]  expIds;
    expIds = 3'b010;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 64'h0000_00F0_0000_0000,
            1'b1, 64'h0000_0000_0000_0003);
      collect(0, id, c, n, z);
      ids[2 - i] = id;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    nCmp++;
    if (ids !== expIds) begin
      nErr++;
      $display("FAIL contention_order: ids=%b expected %b", ids, expIds);
    end
  endtask

  task automatic test_single;
    logic        id;
    logic [6:0]  c;
    logic [63:0] n;
    logic        z;
    issue(1'b1, 64'h0000_0000_0001_0000, 1'b0, 64'd0);
    req0_valid = 1'b0;
    collect(0, id, c, n, z);
    nCmp++;
    if ({id, c, n, z} !== {1'b0, 7'd47, 64'h8000_0000_0000_0000, 1'b0}) begin
      nErr++;
      $display("FAIL single: id=%b cnt=%0d norm=%h zero=%b expected 0 47 8000000000000000 0",
               id, c, n, z);
    end
  endtask

  task automatic test_zero;
    logic        id;
    logic [6:0]  c;
    logic [63:0] n;
    logic        z;
    issue(1'b0, 64'd0, 1'b1, 64'd0);
    req1_valid = 1'b0;
    collect(0, id, c, n, z);
    nCmp++;
    if ({id, c, n, z} !== {1'b1, 7'd64, 64'd0, 1'b1}) begin
      nErr++;
      $display("FAIL zero_op: id=%b cnt=%0d norm=%h zero=%b expected 1 64 0 1",
               id, c, n, z);
    end
  endtask

  task automatic test_msb;
    logic        id;
    logic [6:0]  c;
    logic [63:0] n;
    logic        z;
    issue(1'b1, 64'h8000_0000_0000_0000, 1'b0, 64'd0);
    req0_valid = 1'b0;
    collect(0, id, c, n, z);
    nCmp++;
    if ({c, n, z} !== {7'd0, 64'h8000_0000_0000_0000, 1'b0}) begin
      nErr++;
      $display("FAIL msb: cnt=%0d norm=%h zero=%b expected 0 8000000000000000 0",
               c, n, z);
    end
  endtask

  task automatic test_backpressure;
    logic        id;
    logic [6:0]  c;
    logic [63:0] n;
    logic        z;
    issue(1'b1, 64'h0000_0000_0000_0001, 1'b0, 64'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_data  = 64'h0001_2345_6789_ABCD;
    collect(5, id, c, n, z);
    nCmp++;
    if (req1_ready !== 1'b1) begin
      nErr++;
      $display("FAIL waiting_req: req1_ready=%b expected 1", req1_ready);
    end
    issue(1'b0, 64'd0, 1'b1, 64'h0001_2345_6789_ABCD);
    req1_valid = 1'b0;
    collect(0, id, c, n, z);
    nCmp++;
    if ({id, c} !== {1'b1, 7'd15}) begin
      nErr++;
      $display("FAIL held_req: id=%b cnt=%0d expected 1 15", id, c);
    end
  endtask

  task automatic test_patterns;
    logic        id;
    logic [6:0]  c;
    logic [63:0] n;
    logic        z;
    logic [63:0] d;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      d = d >> $urandom_range(0, 63);
      if (i == 7) d = 64'd1;
      if (i[0]) begin
        issue(1'b0, 64'd0, 1'b1, d);
      end else begin
        issue(1'b1, d, 1'b0, 64'd0);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      collect(0, id, c, n, z);
    end
  endtask

  task automatic test_reset_mid_shift;
    logic        id;
    logic [6:0]  c;
    logic [63:0] n;
    logic        z;
    issue(1'b0, 64'd0, 1'b1, 64'h0000_0F00_0000_0000);
    req1_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    nCmp++;
    if ({resp_valid, busy, resp_id, resp_zero, resp_count,
         resp_norm, lzc_a} !== '0) begin
      nErr++;
      $display("FAIL async_reset: valid=%b busy=%b cnt=%0d lzc_a=%h expected all 0",
               resp_valid, busy, resp_count, lzc_a);
    end
    void'(sb.pop_back());
    lastG = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nCmp++;
      if ({resp_valid, busy} !== 2'b00) begin
        nErr++;
        $display("FAIL dropped_op: valid=%b busy=%b expected 0 0",
                 resp_valid, busy);
      end
    end
    @(posedge clk);
    #1;
    issue(1'b1, 64'h0000_0000_0000_00FF, 1'b0, 64'd0);
    req0_valid = 1'b0;
    collect(0, id, c, n, z);
    nCmp++;
    if ({id, c, n} !== {1'b0, 7'd56, 64'hFF00_0000_0000_0000}) begin
      nErr++;
      $display("FAIL post_reset: id=%b cnt=%0d norm=%h expected 0 56 ff00000000000000",
               id, c, n);
    end
  endtask

  initial begin
    nCmp       = 0;
    nErr       = 0;
    lastG      = 1'b1;
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req0_data  = 64'd0;
    req1_valid = 1'b0;
    req1_data  = 64'd0;
    resp_ready = 1'b0;
    test_reset();
    test_contention();
    test_single();
    test_zero();
    test_msb();
    test_backpressure();
    test_patterns();
    test_reset_mid_shift();
    nCmp++;
    if (sb.size() != 0) begin
      nErr++;
      $display("FAIL leftover: %0d entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
